// File: rtl/demux_pkg.sv
// Shared constants and channel state type for the 1-to-4 registered demultiplexer.
package demux_pkg;
    localparam int DEFAULT_WIDTH = 4;
    localparam int NUM_CH        = 4;
    localparam int SEL_W         = 2;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;
endpackage

// File: rtl/demultiplexer_router_if.sv
// Producer/consumer bundle of the demultiplexer: one input port, four held output channels.
interface demultiplexer_router_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]  in_data;
    logic [SEL_W-1:0]  Sel;
    logic              Enable;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  Y0;
    logic [WIDTH-1:0]  Y1;
    logic [WIDTH-1:0]  Y2;
    logic [WIDTH-1:0]  Y3;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ack;
    logic [CNT_W-1:0]  xfer_count;

    // master = producer plus the four consumers; slave = the router itself
    modport master (
        output in_data, Sel, Enable, in_valid, out_ack,
        input  in_ready, Y0, Y1, Y2, Y3, out_valid, xfer_count
    );

    modport slave (
        input  in_data, Sel, Enable, in_valid, out_ack,
        output in_ready, Y0, Y1, Y2, Y3, out_valid, xfer_count
    );
endinterface

// File: rtl/demultiplexer_router_select_decoder.sv
// Channel index to one-hot, gated by an enable; all-zero when the enable is low.
module select_decoder
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic [NUM_CH-1:0] onehot
);
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dec
            assign onehot[gi] = en && (sel == SEL_W'(gi));
        end
    endgenerate
endmodule

// File: rtl/demultiplexer_router.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ack hold and a saturating transfer counter.
module demultiplexer_router
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
)(
    input  logic                   clk,
    input  logic                   reset,
    demultiplexer_router_if.slave  bus
);
    logic [NUM_CH-1:0]             sel_oh;
    logic [NUM_CH-1:0]             xfer_oh;
    logic [NUM_CH-1:0]             valid_vec;
    logic                          in_ready_int;
    logic                          xfer;
    ch_state_t                     state_reg  [NUM_CH];
    ch_state_t                     state_next [NUM_CH];
    logic [NUM_CH-1:0][WIDTH-1:0]  y_reg;
    logic [NUM_CH-1:0][WIDTH-1:0]  y_next;
    logic [CNT_W-1:0]              cnt_reg;
    logic [CNT_W-1:0]              cnt_next;

    select_decoder u_lookup (
        .sel    (bus.Sel),
        .en     (1'b1),
        .onehot (sel_oh)
    );

    // A channel is open when empty, or when its consumer drains it this same cycle.
    assign in_ready_int = !reset && bus.Enable && |(sel_oh & (~valid_vec | bus.out_ack));
    assign xfer         = bus.in_valid && in_ready_int;

    select_decoder u_strobe (
        .sel    (bus.Sel),
        .en     (xfer),
        .onehot (xfer_oh)
    );

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign valid_vec[gi] = (state_reg[gi] == CH_FULL);
            assign y_next[gi]    = xfer_oh[gi] ? bus.in_data : y_reg[gi];

            // A transfer wins over an ack: the old word is consumed, the new one held.
            always_comb begin
                state_next[gi] = state_reg[gi];
                if (xfer_oh[gi])
                    state_next[gi] = CH_FULL;
                else if (bus.out_ack[gi])
                    state_next[gi] = CH_EMPTY;
            end
        end
    endgenerate

    always_comb begin
        cnt_next = cnt_reg;
        if (xfer && (cnt_reg != {CNT_W{1'b1}}))
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++)
                state_reg[i] <= CH_EMPTY;
            y_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = valid_vec;
    assign bus.xfer_count = cnt_reg;
    assign bus.Y0         = y_reg[0];
    assign bus.Y1         = y_reg[1];
    assign bus.Y2         = y_reg[2];
    assign bus.Y3         = y_reg[3];
endmodule

// File: tb/tb_demultiplexer_router.sv
// Self-checking bench for demultiplexer_router: directed scenarios plus random traffic vs a reference model.
module tb_demultiplexer_router;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    demultiplexer_router_if #(.WIDTH(4), .CNT_W(8)) bus ();

    demultiplexer_router #(.WIDTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         vectors = 0;
    int         errors  = 0;
    int         txn     = 0;
    bit         m_valid [4];
    logic [3:0] m_y     [4];
    int         m_cnt;
    logic       rdy_dut;
    logic       rdy_exp;

    function automatic logic [3:0] dut_y(input int i);
        case (i)
            0:       return bus.Y0;
            1:       return bus.Y1;
            2:       return bus.Y2;
            default: return bus.Y3;
        endcase
    endfunction

    function automatic logic [3:0] model_valid();
        return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    // Drive one cycle, sample in_ready before the edge, advance the model at the edge.
    task automatic apply(input logic rst, input logic en, input logic iv,
                         input logic [1:0] s, input logic [3:0] d, input logic [3:0] ack);
        bit accepted;
        reset        = rst;
        bus.Enable   = en;
        bus.in_valid = iv;
        bus.Sel      = s;
        bus.in_data  = d;
        bus.out_ack  = ack;
        #1;
        rdy_dut  = bus.in_ready;
        rdy_exp  = !rst && en && (!m_valid[s] || ack[s]);
        accepted = iv && rdy_exp;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 1'b0;
                m_y[i]     = 4'h0;
            end
            m_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accepted && (int'(s) == i)) begin
                    m_valid[i] = 1'b1;
                    m_y[i]     = d;
                end else if (ack[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (accepted && m_cnt < 255)
                m_cnt++;
        end
        #1;
        txn++;
        $display("txn %0d rst=%0b en=%0b iv=%0b sel=%0d data=%h ack=%b rdy=%0b ov=%b cnt=%0d",
                 txn, rst, en, iv, s, d, ack, rdy_dut, bus.out_valid, bus.xfer_count);
    endtask

    task automatic test_reset();
        apply(1, 1, 1, 2'd1, 4'h5, 4'h0);
        vectors++;
        if (rdy_dut !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", rdy_dut);
        end
        vectors++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_out_valid got %b want 0000", bus.out_valid);
        end
        vectors++;
        if (bus.xfer_count !== 8'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", bus.xfer_count);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_y(i) !== 4'h0) begin
                errors++; $display("FAIL reset_y%0d got %h want 0", i, dut_y(i));
            end
        end
    endtask

    task automatic test_basic();
        apply(0, 1, 1, 2'd2, 4'hA, 4'h0);
        vectors++;
        if (bus.Y2 !== 4'hA) begin
            errors++; $display("FAIL basic_y2 got %h want a", bus.Y2);
        end
        vectors++;
        if (bus.out_valid !== 4'b0100) begin
            errors++; $display("FAIL basic_out_valid got %b want 0100", bus.out_valid);
        end
        vectors++;
        if (bus.xfer_count !== 8'd1) begin
            errors++; $display("FAIL basic_count got %0d want 1", bus.xfer_count);
        end
        vectors++;
        if ({bus.Y0, bus.Y1, bus.Y3} !== 12'h000) begin
            errors++; $display("FAIL basic_other_y got %h want 000", {bus.Y0, bus.Y1, bus.Y3});
        end
    endtask

    task automatic test_backpressure();
        apply(1, 0, 0, 2'd0, 4'h0, 4'h0);
        apply(0, 1, 1, 2'd1, 4'h3, 4'h0);
        apply(0, 1, 1, 2'd1, 4'h7, 4'h0);
        vectors++;
        if (rdy_dut !== 1'b0) begin
            errors++; $display("FAIL bp_refuse_ready got %b want 0", rdy_dut);
        end
        vectors++;
        if (bus.Y1 !== 4'h3) begin
            errors++; $display("FAIL bp_hold_y1 got %h want 3", bus.Y1);
        end
        apply(0, 1, 1, 2'd1, 4'h7, 4'b0010);
        vectors++;
        if (rdy_dut !== 1'b1) begin
            errors++; $display("FAIL bp_ack_ready got %b want 1", rdy_dut);
        end
        vectors++;
        if (bus.Y1 !== 4'h7 || bus.out_valid[1] !== 1'b1) begin
            errors++; $display("FAIL bp_replace got y1=%h v=%b want y1=7 v=1", bus.Y1, bus.out_valid[1]);
        end
        vectors++;
        if (bus.xfer_count !== 8'd2) begin
            errors++; $display("FAIL bp_count got %0d want 2", bus.xfer_count);
        end
    endtask

    task automatic test_enable();
        apply(1, 0, 0, 2'd0, 4'h0, 4'h0);
        apply(0, 1, 1, 2'd3, 4'h9, 4'h0);
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 1, 2'd0, 4'h5, (k == 2) ? 4'b1000 : 4'b0000);
            vectors++;
            if (rdy_dut !== 1'b0 || bus.out_valid[0] !== 1'b0) begin
                errors++; $display("FAIL en_block k=%0d got rdy=%b v0=%b want 0 0", k, rdy_dut, bus.out_valid[0]);
            end
            vectors++;
            if (bus.xfer_count !== 8'd1) begin
                errors++; $display("FAIL en_count k=%0d got %0d want 1", k, bus.xfer_count);
            end
            vectors++;
            if (bus.out_valid[3] !== ((k < 2) ? 1'b1 : 1'b0) || bus.Y3 !== 4'h9) begin
                errors++; $display("FAIL en_ack3 k=%0d got v3=%b y3=%h want v3=%0b y3=9", k, bus.out_valid[3], bus.Y3, (k < 2));
            end
        end
    endtask

    task automatic test_all_ack();
        apply(1, 0, 0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++)
            apply(0, 1, 1, 2'(i), 4'(i + 1), 4'h0);
        vectors++;
        if (bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL allack_fill got %b want 1111", bus.out_valid);
        end
        apply(0, 1, 0, 2'd0, 4'h0, 4'b1111);
        vectors++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL allack_clear got %b want 0000", bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (dut_y(i) !== 4'(i + 1)) begin
                errors++; $display("FAIL allack_keep_y%0d got %h want %h", i, dut_y(i), 4'(i + 1));
            end
        end
    endtask

    task automatic test_reset_priority();
        apply(0, 1, 1, 2'd0, 4'hC, 4'h0);
        apply(1, 1, 1, 2'd0, 4'hE, 4'h0);
        vectors++;
        if (bus.out_valid !== 4'b0000 || bus.Y0 !== 4'h0 || bus.xfer_count !== 8'd0) begin
            errors++; $display("FAIL rstprio got ov=%b y0=%h cnt=%0d want 0000 0 0", bus.out_valid, bus.Y0, bus.xfer_count);
        end
        apply(0, 1, 1, 2'd0, 4'h6, 4'h0);
        vectors++;
        if (rdy_dut !== 1'b1 || bus.Y0 !== 4'h6 || bus.xfer_count !== 8'd1) begin
            errors++; $display("FAIL rstprio_first got rdy=%b y0=%h cnt=%0d want 1 6 1", rdy_dut, bus.Y0, bus.xfer_count);
        end
    endtask

    task automatic test_saturate();
        apply(1, 0, 0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 300; i++) begin
            apply(0, 1, 1, 2'(i % 4), 4'(i), 4'b1111);
            vectors++;
            if (rdy_dut !== 1'b1) begin
                errors++; $display("FAIL sat_refused i=%0d got rdy=%b want 1", i, rdy_dut);
            end
            vectors++;
            if (int'(bus.xfer_count) != ((i + 1 > 255) ? 255 : i + 1)) begin
                errors++; $display("FAIL sat_count i=%0d got %0d want %0d", i, bus.xfer_count, (i + 1 > 255) ? 255 : i + 1);
            end
        end
    endtask

    task automatic test_random();
        apply(1, 0, 0, 2'd0, 4'h0, 4'h0);
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom & $urandom));
            vectors++;
            if (rdy_dut !== rdy_exp) begin
                errors++; $display("FAIL rand_ready n=%0d got %b want %b", n, rdy_dut, rdy_exp);
            end
            vectors++;
            if (bus.out_valid !== model_valid()) begin
                errors++; $display("FAIL rand_valid n=%0d got %b want %b", n, bus.out_valid, model_valid());
            end
            vectors++;
            if (int'(bus.xfer_count) != m_cnt) begin
                errors++; $display("FAIL rand_count n=%0d got %0d want %0d", n, bus.xfer_count, m_cnt);
            end
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (dut_y(i) !== m_y[i]) begin
                    errors++; $display("FAIL rand_y%0d n=%0d got %h want %h", i, n, dut_y(i), m_y[i]);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.Enable   = 1'b0;
        bus.in_valid = 1'b0;
        bus.Sel      = 2'd0;
        bus.in_data  = 4'h0;
        bus.out_ack  = 4'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_enable();
        test_all_ack();
        test_reset_priority();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/demultiplexer_router.md
# demultiplexer_router

Registered 1-to-4 demultiplexer: accepts a 4-bit word on a single input port and delivers it to one of four output channels selected by `Sel`.
It is the distributing counterpart of the team's 4-to-1 multiplexer.
Each channel holds its word with a valid flag until the consumer acknowledges it, and back-pressure is applied per selected channel.
It sits between a single producer (switch/bus source) and four independent consumers (display digits, LED groups).

## Interface
Parameters:
- `WIDTH`, 4, data width of input and each output channel
- `CNT_W`, 8, width of the saturating transfer counter

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; evaluated on rising edge of `clk`
- `in_data`  in  WIDTH  word to deliver
- `Sel`  in  2  destination channel index 0..3
- `Enable`  in  1  block enable; low blocks all new transfers
- `in_valid`  in  1  producer offers `in_data`
- `in_ready`  out  1  block can accept a word this cycle (combinational)
- `Y0`,`Y1`,`Y2`,`Y3`  out  WIDTH each  channel data registers
- `out_valid`  out  4  bit i high = channel i holds an unconsumed word
- `out_ack`  in  4  bit i high = consumer i takes its word this cycle
- `xfer_count`  out  CNT_W  number of accepted transfers since reset, saturating

## Operation
- Each channel is a two-state machine, with states EMPTY (`out_valid[i]`=0) and FULL (`out_valid[i]`=1).
- `in_ready` = !reset && Enable && (!out_valid[Sel] || out_ack[Sel]).
- A transfer occurs when `in_valid && in_ready`.
- On transfer: `Y[Sel]` <= `in_data`; channel `Sel` goes to FULL.
- On `out_ack[i]` with channel i FULL and no transfer to i: channel i goes to EMPTY; `Y[i]` keeps its value.
- Simultaneous `out_ack[i]` and transfer to i: data is replaced, the channel stays FULL, and the old word counts as consumed.
- `out_ack[i]` on an EMPTY channel is ignored.
- Acks on multiple channels in one cycle are all processed independently.
- `Enable` low:
  - no transfers and `in_ready`=0;
  - acks are still processed;
  - all `Y` and `out_valid` are held.
- Non-selected channels never change due to input activity.
- Data is never dropped. A transfer to a FULL, un-acked channel is refused via `in_ready`=0, and the producer must hold `in_data`/`Sel` until accepted.
- `xfer_count` increments by 1 per transfer and sticks at 2^CNT_W−1.
- `Sel` changing while `in_valid` is high is legal. Each cycle is evaluated with the current `Sel`.

## Timing
- Latency: a transfer at edge N makes `out_valid[Sel]`=1 and `Y[Sel]` valid immediately after edge N (1 cycle from offer to visibility).
- Ack at edge N clears `out_valid[i]` after edge N. A new transfer to the same channel can be accepted in the same cycle as the ack, giving full throughput of 1 word/cycle per channel.
- `in_ready` is combinational from `Sel`, `Enable`, `out_valid`, `out_ack` and `reset`, with no dependence on `in_valid`.
- Reset values: `Y0..Y3`=0, `out_valid`=4'b0000, `xfer_count`=0, `in_ready`=0 while `reset` is high.
- Reset takes priority over a simultaneous transfer or ack.
- Reset mid-operation discards all held words. The first transfer is accepted on the first edge with `reset` low.

## Structure
- Shared package `demux_pkg`:
  - `WIDTH` default;
  - `NUM_CH`=4;
  - `SEL_W`=2;
  - channel state enum {CH_EMPTY, CH_FULL}.
- Sub-module `select_decoder`: `Sel` + enable → one-hot `[3:0]`. Used for both the transfer strobe and `in_ready` channel lookup.
- The top holds four channel registers plus the saturating counter.

## Test plan
- After reset: drive `in_data`=4'hA, `Sel`=2, `in_valid`=1, `Enable`=1 for one cycle.
  - Required: `Y2`=4'hA, `out_valid`=4'b0100, `xfer_count`=1, other `Y`=0.
- Channel 1 FULL with 4'h3, no ack: offer 4'h7 to `Sel`=1.
  - Required: `in_ready`=0, `Y1` stays 4'h3.
  - Then assert `out_ack[1]` in the same cycle: transfer accepted, `Y1`=4'h7, `out_valid[1]` stays 1.
- `Enable`=0 with `in_valid`=1 for 5 cycles on `Sel`=0: `in_ready`=0, `out_valid[0]`=0, `xfer_count` unchanged. Ack on a FULL channel 3 still clears `out_valid[3]`.
- Fill all four channels with 1,2,3,4, then `out_ack`=4'b1111: `out_valid`=0 next edge and `Y0..Y3` retain 1,2,3,4.
- Assert `reset` in the same cycle as a transfer to `Sel`=0: `out_valid`=0, `Y0`=0, `xfer_count`=0.
- 300 continuous transfers with `Sel` cycling 0..3 and acks each cycle: `xfer_count` saturates at 255 and no transfer is refused.
